scanout_fetcher: RTL and testbench
==================================

Name: scanout_fetcher

Overview:
- Pixel-side consumer of the paged byte memory: streams one frame's worth of bytes out of memory, in address order, into a small prefetch FIFO.
- Presents the bytes to the pixel pipeline through a valid/ready interface.
- Sits directly downstream of the memory block: drives its Address/PageMux/Read and captures its DataOut.
- Hides memory read latency from the pixel pipe and flags underruns.

Parameters:
- A, 18: page address width; matches the memory block.
- P, 1: page mux bits; matches the memory block.
- DEPTH, 16: FIFO depth in bytes; power of two, minimum 4.
- RD_LAT, 2: cycles from MemRead high to MemDataIn valid; minimum 1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- FrameStart  in  1  one-cycle pulse; (re)starts a frame fetch.
- BaseAddress  in  A  start address; sampled on FrameStart.
- BasePage  in  P  start page; sampled on FrameStart.
- FrameBytes  in  A+P  bytes to fetch; sampled on FrameStart.
- MemAddress  out  A  read address to memory.
- MemPageMux  out  P  page select to memory.
- MemRead  out  1  one-cycle read strobe.
- MemDataIn  in  8  memory DataOut.
- PixelData  out  8  FIFO head byte.
- PixelValid  out  1  FIFO non-empty.
- PixelReady  in  1  pixel pipe consumes the head byte when PixelValid is high.
- FrameDone  out  1  one-cycle pulse when the frame has fully drained.
- Underrun  out  1  sticky; set when PixelReady is high, PixelValid is low, and state is not Idle.

Behaviour:
- Reset: all outputs 0; state Idle; FIFO empty; in-flight tracker cleared.
- States: Idle, Fetch, Drain.
- Idle -> Fetch on FrameStart:
  - address := BaseAddress; page := BasePage; remaining := FrameBytes.
  - FIFO flushed; Underrun cleared.
- FrameStart with FrameBytes = 0: go to Drain instead; FrameDone pulses the following cycle.
- Fetch: MemRead asserts in a cycle when both hold:
  - remaining > 0;
  - occupancy + inflight < DEPTH.
  - Maximum one read per cycle; back-to-back reads allowed.
- Address/page tracking:
  - MemAddress/MemPageMux show the current address and page, and are valid in the MemRead cycle.
  - After each read: address += 1 and remaining -= 1.
  - Address wraps 2^A-1 -> 0; page += 1 on that wrap, modulo 2^P.
- Fetch -> Drain in the cycle the read with remaining = 1 issues.
- In-flight tracker: RD_LAT-bit shift register of read tokens. A token leaving the register writes MemDataIn into the FIFO that cycle.
  - The push cannot overflow because of the issue condition.
- Drain -> Idle when the FIFO is empty and inflight = 0; FrameDone pulses on that transition cycle.
- FIFO:
  - Show-ahead: PixelData = head byte whenever PixelValid is high.
  - Pop latency: the next byte appears the cycle after the pop.
  - Simultaneous push and pop keeps occupancy unchanged; a push into an empty FIFO becomes visible the next cycle.
- FrameStart during Fetch or Drain:
  - Aborts the current frame; no FrameDone for the aborted frame.
  - Clears the FIFO and tracker, so late MemDataIn from old reads is dropped.
  - Reloads from the inputs and enters Fetch (or Drain if FrameBytes = 0).
- Idle: PixelReady is ignored and Underrun is not set.
- Asynchronous Reset mid-frame returns to the reset state immediately; no FrameDone.

Optional Feature:
- Macro: UNDERRUN_REPEAT_EN.
- Defined: while PixelValid = 0, PixelData holds the last byte popped (0x00 if nothing has been popped since Reset or FrameStart).
- Undefined: PixelData = 0x00 whenever PixelValid = 0.
- Fetch behaviour is identical in both builds.

Test Plan:
- Basic stream: BaseAddress=0x00010, BasePage=0, FrameBytes=8, RD_LAT=2, PixelReady=1, memory returns low byte of address.
  - Expect PixelData 0x10..0x17 in order.
  - Expect exactly 8 MemRead pulses and one FrameDone; Underrun stays 0 after the initial fill only if PixelReady is raised once PixelValid is high.
- Backpressure: FrameBytes=40, DEPTH=16, PixelReady=0 for 50 cycles.
  - Expect MemRead to stop with occupancy = 16 and inflight = 0.
  - Release PixelReady: all 40 bytes are delivered in order.
- Page wrap: BaseAddress=0x3FFFE, BasePage=0, FrameBytes=4.
  - Expect addresses/pages 0x3FFFE/0, 0x3FFFF/0, 0x00000/1, 0x00001/1.
- Underrun: PixelReady=1 from the FrameStart cycle.
  - Expect Underrun = 1 by the cycle after FrameStart, staying set until the next FrameStart.
  - UNDERRUN_REPEAT_EN build: PixelData = 0x00 before the first pop.
- Abort: FrameStart at the 3rd MemRead of a 10-byte frame, new BaseAddress=0x00100.
  - Expect no old-frame bytes on PixelData and the first delivered byte 0x00 (address 0x100); one FrameDone total.
- Zero length: FrameBytes=0.
  - Expect no MemRead, PixelValid=0, and FrameDone two cycles after FrameStart.

Source files
------------

// File: rtl/scanout_fetcher.sv
// rtl/scanout_fetcher.sv - streams a frame of bytes from paged memory into a show-ahead pixel FIFO
// Optional: define UNDERRUN_REPEAT_EN to hold the last popped byte on PixelData while the FIFO is empty.
module scanout_fetcher #(
   parameter int A      = 18,
   parameter int P      = 1,
   parameter int DEPTH  = 16,
   parameter int RD_LAT = 2
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           FrameStart,
   input  logic [A-1:0]   BaseAddress,
   input  logic [P-1:0]   BasePage,
   input  logic [A+P-1:0] FrameBytes,
   output logic [A-1:0]   MemAddress,
   output logic [P-1:0]   MemPageMux,
   output logic           MemRead,
   input  logic [7:0]     MemDataIn,
   output logic [7:0]     PixelData,
   output logic           PixelValid,
   input  logic           PixelReady,
   output logic           FrameDone,
   output logic           Underrun
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

   state_t            state_q, state_d;
   logic [A+P-1:0]    cursor_q, cursor_d;
   logic [A+P-1:0]    remaining_q, remaining_d;
   logic [RD_LAT-1:0] tokens_q, tokens_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              underrun_q, underrun_d;
   logic              done_q, done_d;
   logic [7:0]        fifo_q [DEPTH];
   logic              mem_read, push, pop, fifo_we;
   logic [31:0]       inflight;
   logic [7:0]        head;
`ifdef UNDERRUN_REPEAT_EN
   logic [7:0]        last_q, last_d;
`endif

   assign head = fifo_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      cursor_d    = cursor_q;
      remaining_d = remaining_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      underrun_d  = underrun_q;
      done_d      = 1'b0;
`ifdef UNDERRUN_REPEAT_EN
      last_d      = last_q;
`endif
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++) inflight = inflight + 32'(tokens_q[i]);

      // Reads already in flight reserve their FIFO slot, so a token push can never overflow.
      mem_read = (state_q == S_FETCH) && !FrameStart && (remaining_q != '0)
                 && ((32'(count_q) + inflight) < 32'(DEPTH));
      tokens_d = RD_LAT'({tokens_q, mem_read});
      push     = tokens_q[RD_LAT-1];
      pop      = (count_q != '0) && PixelReady;
      fifo_we  = push && !FrameStart;

      if (mem_read) begin
         // {page, address} as one counter: address wrap carries into the page.
         cursor_d    = cursor_q + (A+P)'(1);
         remaining_d = remaining_q - (A+P)'(1);
         if (remaining_q == (A+P)'(1)) state_d = S_DRAIN;
      end

      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef UNDERRUN_REPEAT_EN
         last_d   = head;
`endif
      end
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);

      if ((state_q != S_IDLE) && PixelReady && (count_q == '0)) underrun_d = 1'b1;

      if ((state_q == S_DRAIN) && (count_q == '0) && (inflight == '0)) begin
         state_d = S_IDLE;
         done_d  = 1'b1;
      end

      // A new frame overrides everything, including an abort of the current one.
      if (FrameStart) begin
         cursor_d    = {BasePage, BaseAddress};
         remaining_d = FrameBytes;
         tokens_d    = '0;
         rd_ptr_d    = '0;
         wr_ptr_d    = '0;
         count_d     = '0;
         underrun_d  = 1'b0;
         done_d      = 1'b0;
`ifdef UNDERRUN_REPEAT_EN
         last_d      = 8'h00;
`endif
         state_d     = (FrameBytes == '0) ? S_DRAIN : S_FETCH;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         cursor_q    <= '0;
         remaining_q <= '0;
         tokens_q    <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         underrun_q  <= 1'b0;
         done_q      <= 1'b0;
`ifdef UNDERRUN_REPEAT_EN
         last_q      <= 8'h00;
`endif
      end else begin
         state_q     <= state_d;
         cursor_q    <= cursor_d;
         remaining_q <= remaining_d;
         tokens_q    <= tokens_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         underrun_q  <= underrun_d;
         done_q      <= done_d;
`ifdef UNDERRUN_REPEAT_EN
         last_q      <= last_d;
`endif
      end
   end

   always_ff @(posedge Clk) begin
      if (fifo_we) fifo_q[wr_ptr_q] <= MemDataIn;
   end

   assign MemAddress = cursor_q[A-1:0];
   assign MemPageMux = cursor_q[A+P-1:A];
   assign MemRead    = mem_read;
   assign PixelValid = (count_q != '0);
   assign FrameDone  = done_q;
   assign Underrun   = underrun_q;
`ifdef UNDERRUN_REPEAT_EN
   assign PixelData  = PixelValid ? head : last_q;
`else
   assign PixelData  = PixelValid ? head : 8'h00;
`endif

endmodule

// File: tb/tb_scanout_fetcher.sv
// tb/tb_scanout_fetcher.sv - scoreboard bench for scanout_fetcher with a fixed-latency memory model
module tb_scanout_fetcher;
   localparam int A      = 18;
   localparam int P      = 1;
   localparam int DEPTH  = 16;
   localparam int RD_LAT = 2;

   logic           Clk = 1'b0;
   logic           Reset;
   logic           FrameStart;
   logic [A-1:0]   BaseAddress;
   logic [P-1:0]   BasePage;
   logic [A+P-1:0] FrameBytes;
   logic [A-1:0]   MemAddress;
   logic [P-1:0]   MemPageMux;
   logic           MemRead;
   logic [7:0]     MemDataIn;
   logic [7:0]     PixelData;
   logic           PixelValid;
   logic           PixelReady;
   logic           FrameDone;
   logic           Underrun;

   always #5 Clk = ~Clk;

   scanout_fetcher #(.A(A), .P(P), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
      .Clk(Clk), .Reset(Reset), .FrameStart(FrameStart),
      .BaseAddress(BaseAddress), .BasePage(BasePage), .FrameBytes(FrameBytes),
      .MemAddress(MemAddress), .MemPageMux(MemPageMux), .MemRead(MemRead),
      .MemDataIn(MemDataIn), .PixelData(PixelData), .PixelValid(PixelValid),
      .PixelReady(PixelReady), .FrameDone(FrameDone), .Underrun(Underrun)
   );

   // memory returns the low byte of the read address RD_LAT cycles after MemRead
   logic [7:0] rd_pipe [RD_LAT];
   always @(posedge Clk) begin
      for (int i = RD_LAT-1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= MemRead ? MemAddress[7:0] : 8'hEE;
   end
   assign MemDataIn = rd_pipe[RD_LAT-1];

   int n_checks = 0;
   int n_fail   = 0;
   int n_reads  = 0;
   int n_done   = 0;
   int reads_snap, done_snap;
   logic [7:0]     exp_q[$];
   logic [A+P-1:0] addr_log[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (!Reset) begin
         if (MemRead) begin
            n_reads++;
            addr_log.push_back({MemPageMux, MemAddress});
         end
         if (FrameDone) n_done++;
         if (PixelValid && PixelReady && !FrameStart) begin
            if (exp_q.size() == 0) check("sb_extra_byte", exp_q.size(), 1);
            else                   check("pixel_byte", PixelData, exp_q.pop_front());
         end
      end
   end

   task automatic start_frame(input logic [A-1:0] base, input logic [P-1:0] page,
                              input logic [A+P-1:0] nbytes, input logic rdy);
      logic [A+P-1:0] cur;
      @(posedge Clk); #1;
      FrameStart  = 1'b1;
      BaseAddress = base;
      BasePage    = page;
      FrameBytes  = nbytes;
      PixelReady  = rdy;
      exp_q.delete();
      addr_log.delete();
      cur = {page, base};
      for (int i = 0; i < int'(nbytes); i++) begin
         exp_q.push_back(cur[7:0]);
         cur = cur + (A+P)'(1);
      end
      reads_snap = n_reads;
      done_snap  = n_done;
      @(posedge Clk); #1;
      FrameStart = 1'b0;
   endtask

   task automatic drain_stream(input string tag);
      int budget;
      budget = 0;
      while (!PixelValid && budget < 200) begin @(negedge Clk); #1; budget++; end
      if (!PixelValid) check({tag, "_valid_timeout"}, PixelValid, 1);
      @(posedge Clk); #1;
      PixelReady = 1'b1;
      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin @(posedge Clk); #1; budget++; end
      if (exp_q.size() != 0) check({tag, "_drain_timeout"}, exp_q.size(), 0);
      PixelReady = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int budget;
      budget = 0;
      while (n_done == done_snap && budget < 200) begin @(negedge Clk); #1; budget++; end
      check({tag, "_frame_done"}, n_done - done_snap, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [A+P-1:0] exp_addr [4];
      int budget, d0;
      exp_addr = '{19'h3FFFE, 19'h3FFFF, 19'h40000, 19'h40001};
      Reset = 1'b1; FrameStart = 1'b0; BaseAddress = '0; BasePage = '0;
      FrameBytes = '0; PixelReady = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_memread", MemRead, 0);
      check("rst_valid", PixelValid, 0);
      check("rst_data", PixelData, 0);
      check("rst_done", FrameDone, 0);
      check("rst_underrun", Underrun, 0);
      check("rst_addr", MemAddress, 0);
      @(posedge Clk); #1;
      Reset = 1'b0;

      // basic stream
      start_frame(18'h00010, 1'b0, 19'd8, 1'b0);
      drain_stream("basic");
      wait_done("basic");
      check("basic_reads", n_reads - reads_snap, 8);
      check("basic_underrun", Underrun, 0);

      // backpressure: fill stops at DEPTH with nothing in flight
      start_frame(18'h00200, 1'b0, 19'd40, 1'b0);
      repeat (40) @(negedge Clk);
      #1;
      check("bp_reads_stalled", n_reads - reads_snap, DEPTH);
      repeat (10) @(negedge Clk);
      #1;
      check("bp_reads_hold", n_reads - reads_snap, DEPTH);
      check("bp_valid", PixelValid, 1);
      drain_stream("bp");
      wait_done("bp");
      check("bp_reads_total", n_reads - reads_snap, 40);
      check("bp_underrun", Underrun, 0);

      // address wrap carries into the page
      start_frame(18'h3FFFE, 1'b0, 19'd4, 1'b0);
      drain_stream("wrap");
      wait_done("wrap");
      check("wrap_read_count", addr_log.size(), 4);
      for (int i = 0; i < addr_log.size() && i < 4; i++) check("wrap_addr", addr_log[i], exp_addr[i]);

      // underrun: ready high from the FrameStart cycle
      start_frame(18'h00020, 1'b0, 19'd4, 1'b1);
      @(negedge Clk); #1;
      check("underrun_pre_pop_data", PixelData, 0);
      @(negedge Clk); #1;
      check("underrun_set", Underrun, 1);
      budget = 0;
      while (exp_q.size() != 0 && budget < 200) begin @(negedge Clk); #1; budget++; end
      check("underrun_stream_left", exp_q.size(), 0);
      wait_done("underrun");
      check("underrun_sticky", Underrun, 1);
      PixelReady = 1'b0;

      // abort at the third read of a 10-byte frame
      start_frame(18'h00040, 1'b0, 19'd10, 1'b0);
      check("abort_underrun_cleared", Underrun, 0);
      budget = 0;
      while ((n_reads - reads_snap) < 2 && budget < 50) begin @(negedge Clk); #1; budget++; end
      check("abort_pre_reads", n_reads - reads_snap, 2);
      d0 = n_done;
      start_frame(18'h00100, 1'b0, 19'd10, 1'b0);
      drain_stream("abort");
      wait_done("abort");
      repeat (5) @(negedge Clk);
      #1;
      check("abort_done_total", n_done - d0, 1);
      check("abort_reads", n_reads - reads_snap, 10);

      // zero-length frame
      start_frame(18'h00000, 1'b0, 19'd0, 1'b0);
      @(negedge Clk); #1;
      check("zero_done_t1", FrameDone, 0);
      @(negedge Clk); #1;
      check("zero_done_t2", FrameDone, 1);
      check("zero_reads", n_reads - reads_snap, 0);
      check("zero_valid", PixelValid, 0);

      repeat (5) @(negedge Clk);
      check("sb_leftover", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
